gpio_seg_scan: RTL and testbench

Downstream consumer of the memory-mapped GPIO register word. It takes the 32-bit GPIO output and drives an 8-digit, common-anode, multiplexed seven-segment display, one hex nibble per digit. The GPIO word is snapshotted once per scan frame, so a CPU store never produces a torn display. Dead-time blanking between digit slots prevents ghosting.

---
 rtl/gpio_seg_scan_if.sv | 19 +
 rtl/gpio_seg_scan.sv | 97 +++++++++
 tb/tb_gpio_seg_scan.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/gpio_seg_scan_if.sv
// GPIO-to-display signal bundle: scan enable and GPIO word in, display drive out.
interface gpio_seg_scan_if;
    logic        en;
    logic [31:0] gpio_in;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    modport master (
        output en, gpio_in,
        input  an, seg, dp, frame_start
    );

    modport slave (
        input  en, gpio_in,
        output an, seg, dp, frame_start
    );
endinterface

// File: rtl/gpio_seg_scan.sv
// Eight-digit multiplexed common-anode seven-segment scanner for the GPIO word.
// The word is snapshotted once per frame; each digit slot opens with a blank gap.
module gpio_seg_scan #(
    parameter int unsigned DIV  = 50000,
    parameter int unsigned DEAD = 8,
    parameter int unsigned LZB  = 0
) (
    input  logic            clk,
    input  logic            rst,
    gpio_seg_scan_if.slave  bus
);
    localparam int unsigned   CW     = $clog2(DIV);
    localparam logic [CW-1:0] LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] DEAD_C = CW'(DEAD);

    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    d, d_nx;
    logic [31:0]   snap, snap_nx;
    logic          load;
    logic          blank_lz;
    logic [7:0]    an_q, an_nx;
    logic [6:0]    seg_q, seg_nx;
    logic          fs_q;

    // Active-high gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // Next slot position, snapshot load, and decode of the post-edge state.
    always_comb begin
        cnt_nx   = cnt;
        d_nx     = d;
        snap_nx  = snap;
        load     = bus.en && (cnt == '0) && (d == '0);
        an_nx    = '1;
        seg_nx   = '1;
        blank_lz = 1'b0;
        if (bus.en) begin
            if (cnt == LAST) begin
                cnt_nx = '0;
                d_nx   = d + 3'd1;
            end else begin
                cnt_nx = cnt + 1'b1;
            end
            if (load) begin
                snap_nx = bus.gpio_in;
            end
            blank_lz = (LZB != 0) && (d_nx != 3'd0) && ((snap_nx >> {d_nx, 2'b00}) == '0);
            if ((cnt_nx >= DEAD_C) && !blank_lz) begin
                an_nx  = ~(8'b1 << d_nx);
                seg_nx = ~hex7(snap_nx[{d_nx, 2'b00} +: 4]);
            end
        end
    end

    // State and registered display outputs; rst takes priority over en.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            d     <= '0;
            snap  <= '0;
            an_q  <= '1;
            seg_q <= '1;
            fs_q  <= 1'b0;
        end else begin
            cnt   <= cnt_nx;
            d     <= d_nx;
            snap  <= snap_nx;
            an_q  <= an_nx;
            seg_q <= seg_nx;
            fs_q  <= load;
        end
    end

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.dp          = 1'b1;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_gpio_seg_scan.sv
// Bench for gpio_seg_scan: table vectors, directed corner sequences, random run vs a position-based model.
module tb_gpio_seg_scan;
    localparam int unsigned DIV   = 8;
    localparam int unsigned DEAD  = 2;
    localparam int unsigned FRAME = 8 * DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gpio_seg_scan_if bus0 ();
    gpio_seg_scan_if bus1 ();

    gpio_seg_scan #(.DIV(DIV), .DEAD(DEAD), .LZB(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    gpio_seg_scan #(.DIV(DIV), .DEAD(DEAD), .LZB(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int checks = 0;
    int errors = 0;

    // Model: k = enabled edges since reset; snapshot captured when a frame boundary is crossed.
    int unsigned k = 0;
    logic [31:0] msnap = '0;
    logic [31:0] cur_gpio = '0;
    int unsigned cyc = 0;
    int unsigned last_fs = 0;
    int unsigned fs_interval = 0;
    logic [7:0] prev_an = 8'hFF;
    logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        logic        rst;
        logic        en;
        logic [31:0] gpio;
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        fs;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (k=%0d cyc=%0d)", name, act, exp, k, cyc);
        end
    endtask

    // Expected {an, seg} for display position p of a frame holding word s.
    function automatic logic [14:0] model_out(input int unsigned p, input logic [31:0] s, input bit lzb);
        int unsigned dig;
        int unsigned pos;
        logic [3:0]  nib;
        dig = p / DIV;
        pos = p % DIV;
        if (pos < DEAD) return {8'hFF, 7'h7F};
        if (lzb && dig > 0 && longint'(s) < (64'd1 << (4 * dig))) return {8'hFF, 7'h7F};
        nib = 4'((s / (32'd1 << (4 * dig))) % 16);
        return {8'hFF - 8'((1 << dig)), 7'h7F - HEX[nib]};
    endfunction

    task automatic step(input logic r, input logic e, input logic [31:0] g);
        logic [14:0] e0, e1;
        logic        efs;
        rst = r;
        bus0.en = e; bus1.en = e;
        bus0.gpio_in = g; bus1.gpio_in = g;
        cur_gpio = g;
        @(posedge clk);
        cyc++;
        efs = 1'b0;
        if (r) begin
            k = 0;
            msnap = '0;
            e0 = {8'hFF, 7'h7F};
        end else if (e) begin
            if (k % FRAME == 0) begin
                msnap = g;
                efs = 1'b1;
            end
            k++;
            e0 = model_out(k % FRAME, msnap, 1'b0);
        end else begin
            e0 = {8'hFF, 7'h7F};
        end
        e1 = (r || !e) ? e0 : model_out(k % FRAME, msnap, 1'b1);
        #1;
        chk("an", {24'h0, bus0.an}, {24'h0, e0[14:7]});
        chk("seg", {25'h0, bus0.seg}, {25'h0, e0[6:0]});
        chk("fs", {31'h0, bus0.frame_start}, {31'h0, efs});
        chk("dp", {31'h0, bus0.dp}, 32'h1);
        chk("an_lzb", {24'h0, bus1.an}, {24'h0, e1[14:7]});
        chk("seg_lzb", {25'h0, bus1.seg}, {25'h0, e1[6:0]});
        chk("one_anode", ($countones(~bus0.an) <= 1) ? 32'h1 : 32'h0, 32'h1);
        chk("anode_gap", (prev_an != 8'hFF && bus0.an != 8'hFF && prev_an != bus0.an) ? 32'h1 : 32'h0, 32'h0);
        prev_an = bus0.an;
        if (bus0.frame_start) begin
            fs_interval = cyc - last_fs;
            last_fs = cyc;
        end
    endtask

    task automatic run_to(input int unsigned target);
        for (int unsigned i = 0; i < 1000 && k < target; i++) step(1'b0, 1'b1, cur_gpio);
        chk("run_to_reached", k, target);
    endtask

    initial begin
        // Reset with en=1 and all-ones GPIO, then the start of a scan of 12345678.
        for (int i = 0; i < 3; i++) tbl[i] = '{1'b1, 1'b1, 32'hFFFFFFFF, 8'hFF, 7'h7F, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 32'h12345678, 8'hFF, 7'h7F, 1'b1};
        for (int i = 4; i < 10; i++) tbl[i] = '{1'b0, 1'b1, 32'h12345678, 8'hFE, 7'h00, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 32'h12345678, 8'hFF, 7'h7F, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 32'h12345678, 8'hFF, 7'h7F, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 32'h12345678, 8'hFD, 7'h78, 1'b0};

        bus0.en = 1'b0; bus1.en = 1'b0;
        bus0.gpio_in = '0; bus1.gpio_in = '0;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].gpio);
            chk("tbl_an", {24'h0, bus0.an}, {24'h0, tbl[i].an});
            chk("tbl_seg", {25'h0, bus0.seg}, {25'h0, tbl[i].seg});
            chk("tbl_fs", {31'h0, bus0.frame_start}, {31'h0, tbl[i].fs});
        end

        // Digit 7 of the first frame, then frame_start period.
        run_to(7 * DIV + 4);
        chk("dig7_an", {24'h0, bus0.an}, 32'h7F);
        chk("dig7_seg", {25'h0, bus0.seg}, 32'h79);
        run_to(FRAME + 1);
        chk("fs_period", fs_interval, FRAME);

        // Tearing: clear GPIO during digit 3; this frame keeps 4,3,2,1.
        run_to(FRAME + 3 * DIV + 4);
        cur_gpio = 32'h0;
        run_to(FRAME + 4 * DIV + 4);
        chk("tear_d4", {24'h0, bus0.an, 1'b0, bus0.seg}, {24'h0, 8'hEF, 8'h19});
        run_to(FRAME + 5 * DIV + 4);
        chk("tear_d5", {24'h0, bus0.an, 1'b0, bus0.seg}, {24'h0, 8'hDF, 8'h30});
        run_to(FRAME + 6 * DIV + 4);
        chk("tear_d6", {24'h0, bus0.an, 1'b0, bus0.seg}, {24'h0, 8'hBF, 8'h24});
        run_to(FRAME + 7 * DIV + 4);
        chk("tear_d7", {24'h0, bus0.an, 1'b0, bus0.seg}, {24'h0, 8'h7F, 8'h79});
        run_to(2 * FRAME + 4);
        chk("zero_d0", {24'h0, bus0.an, 1'b0, bus0.seg}, {24'h0, 8'hFE, 8'h40});
        run_to(2 * FRAME + 7 * DIV + 4);
        chk("zero_d7", {24'h0, bus0.an, 1'b0, bus0.seg}, {24'h0, 8'h7F, 8'h40});

        // Enable gating mid-slot at digit 5.
        run_to(3 * FRAME + 5 * DIV + 4);
        step(1'b0, 1'b0, cur_gpio);
        chk("gate_an", {24'h0, bus0.an}, 32'hFF);
        chk("gate_seg", {25'h0, bus0.seg}, 32'h7F);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, cur_gpio);
        step(1'b0, 1'b1, cur_gpio);
        chk("gate_resume", {24'h0, bus0.an, 1'b0, bus0.seg}, {24'h0, 8'hDF, 8'h40});
        run_to(4 * FRAME + 1);
        chk("gate_frame_len", fs_interval, FRAME + 10);

        // Reset during digit 6 drive, then a fresh frame with A0 (LZB check).
        cur_gpio = 32'h000000A0;
        run_to(4 * FRAME + 6 * DIV + 4);
        step(1'b1, 1'b1, cur_gpio);
        chk("rst_mid_an", {24'h0, bus0.an}, 32'hFF);
        chk("rst_mid_seg", {25'h0, bus0.seg}, 32'h7F);
        step(1'b0, 1'b1, cur_gpio);
        chk("rst_fresh_fs", {31'h0, bus0.frame_start}, 32'h1);
        run_to(4);
        chk("lzb_d0", {24'h0, bus1.an, 1'b0, bus1.seg}, {24'h0, 8'hFE, 8'h40});
        run_to(DIV + 4);
        chk("lzb_d1", {24'h0, bus1.an, 1'b0, bus1.seg}, {24'h0, 8'hFD, 8'h08});
        run_to(2 * DIV + 4);
        chk("lzb_d2", {24'h0, bus1.an, 1'b0, bus1.seg}, {24'h0, 8'hFF, 8'h7F});
        chk("nolzb_d2", {24'h0, bus0.an, 1'b0, bus0.seg}, {24'h0, 8'hFB, 8'h40});
        run_to(7 * DIV + 4);
        chk("lzb_d7", {24'h0, bus1.an}, 32'hFF);

        // Random run: random words, sparse enable drops and resets.
        for (int i = 0; i < 2000; i++) begin
            logic r, e;
            logic [31:0] g;
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 9) != 0);
            g = ($urandom_range(0, 3) == 0) ? ($urandom() >> (4 * $urandom_range(0, 7))) : cur_gpio;
            step(r, e, g);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
